// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared constants for the unified byte-wide RAM/IO bus arbiter.
package mem_arbiter_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  localparam logic [1:0]  IO_REGION = 2'b11;
  localparam logic [31:0] ZERO_WORD = '0;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   len_bytes = 3'd1;
      LEN_H:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Fetch port, data port and RAM/IO pins of the arbiter, grouped as one bundle.
interface mem_arbiter_ctrl_if #(parameter int unsigned ADDR_W = 32);

  logic              inst_needed;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_cancel;
  logic              inst_rdy;
  logic              inst_busy;
  logic [31:0]       inst_data;

  logic              data_needed;
  logic              data_wr;
  logic [1:0]        data_len;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_rdy;
  logic              data_busy;
  logic [31:0]       data_rdata;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic              io_buffer_full;

  modport slave (
    input  inst_needed, inst_addr, inst_cancel,
    input  data_needed, data_wr, data_len, data_addr, data_wdata,
    input  ram_din, io_buffer_full,
    output inst_rdy, inst_busy, inst_data,
    output data_rdy, data_busy, data_rdata,
    output ram_dout, ram_a, ram_wr
  );

  modport master (
    output inst_needed, inst_addr, inst_cancel,
    output data_needed, data_wr, data_len, data_addr, data_wdata,
    output ram_din, io_buffer_full,
    input  inst_rdy, inst_busy, inst_data,
    input  data_rdy, data_busy, data_rdata,
    input  ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_byte_assembler.sv
// Little-endian 4x8 read assembly buffer with zero-extension, plus store byte select.
module mem_byte_assembler
  import mem_arbiter_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load_wdata,
  input  logic [31:0] wdata_in,
  input  logic        capture,
  input  logic [1:0]  cap_idx,
  input  logic [7:0]  din,
  input  logic [1:0]  len,
  input  logic [1:0]  sel_idx,
  output logic [31:0] word,
  output logic [7:0]  wbyte
);

  logic [31:0] buffer;
  logic [31:0] merged;
  logic [31:0] wdata_q;

  // word includes the byte being captured this cycle so the last byte is usable at once
  always_comb begin
    merged = buffer;
    if (capture) merged[{cap_idx, 3'b000} +: 8] = din;
  end

  always_comb begin
    word = merged;
    case (len)
      LEN_B:   word = {24'h0, merged[7:0]};
      LEN_H:   word = {16'h0, merged[15:0]};
      default: word = merged;
    endcase
  end

  assign wbyte = wdata_q[{sel_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer  <= ZERO_WORD;
      wdata_q <= ZERO_WORD;
    end else begin
      if (clear)        buffer <= ZERO_WORD;
      else if (capture) buffer <= merged;
      if (load_wdata)   wdata_q <= wdata_in;
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Owner of the byte-wide RAM/IO bus: arbitrates fetch vs data, serialises bytes.
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IO_MASK_HI = 17
) (
  input logic               clk,
  input logic               rst,
  mem_arbiter_ctrl_if.slave bus
);

  logic [1:0]        state;
  logic              owner_inst;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] ram_a_q;
  logic [1:0]        len;
  logic [2:0]        k;
  logic [2:0]        k_inc;
  logic [2:0]        nbytes;
  logic [1:0]        cap_idx;
  logic              cancel_q;
  logic              cancel_now;
  logic              hold;
  logic [31:0]       inst_data_q;
  logic [31:0]       data_rdata_q;
  logic [31:0]       word;
  logic              asm_clear;
  logic              asm_load;
  logic              asm_capture;

  assign nbytes     = len_bytes(len);
  assign k_inc      = k + 3'd1;
  assign cap_idx    = k[1:0] - 2'd1;
  assign hold       = (state == ST_WRITE) && (addr[IO_MASK_HI -: 2] == IO_REGION)
                      && bus.io_buffer_full;
  assign cancel_now = owner_inst && (cancel_q || bus.inst_cancel);

  assign asm_clear   = (state == ST_IDLE);
  assign asm_load    = (state == ST_IDLE) && bus.data_needed;
  assign asm_capture = (state == ST_READ) && (k != 3'd0);

  mem_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .load_wdata (asm_load),
    .wdata_in   (bus.data_wdata),
    .capture    (asm_capture),
    .cap_idx    (cap_idx),
    .din        (bus.ram_din),
    .len        (len),
    .sel_idx    (k[1:0]),
    .word       (word),
    .wbyte      (bus.ram_dout)
  );

  // READ runs k = 0..N: address k is issued while byte k-1 (issued last cycle) is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner_inst   <= 1'b0;
      addr         <= '0;
      ram_a_q      <= '0;
      len          <= LEN_B;
      k            <= '0;
      cancel_q     <= 1'b0;
      inst_data_q  <= ZERO_WORD;
      data_rdata_q <= ZERO_WORD;
    end else begin
      case (state)
        ST_IDLE: begin
          cancel_q <= 1'b0;
          k        <= '0;
          if (bus.data_needed) begin
            owner_inst <= 1'b0;
            addr       <= bus.data_addr;
            ram_a_q    <= bus.data_addr;
            len        <= bus.data_len;
            state      <= bus.data_wr ? ST_WRITE : ST_READ;
          end else if (bus.inst_needed) begin
            owner_inst <= 1'b1;
            addr       <= bus.inst_addr;
            ram_a_q    <= bus.inst_addr;
            len        <= LEN_W;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          if (cancel_now) cancel_q <= 1'b1;
          if (k == nbytes) begin
            state <= ST_DONE;
            if (owner_inst) begin
              if (!cancel_now) inst_data_q <= word;
            end else begin
              data_rdata_q <= word;
            end
          end else begin
            k <= k_inc;
            if (k_inc < nbytes) ram_a_q <= addr + ADDR_W'(k_inc);
          end
        end
        ST_WRITE: begin
          if (!hold) begin
            if (k_inc == nbytes) begin
              state <= ST_DONE;
            end else begin
              k       <= k_inc;
              ram_a_q <= addr + ADDR_W'(k_inc);
            end
          end
        end
        ST_DONE: begin
          if (cancel_now) cancel_q <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_a      = ram_a_q;
  assign bus.ram_wr     = (state == ST_WRITE) && !hold;
  assign bus.inst_rdy   = (state == ST_DONE) && owner_inst && !cancel_now;
  assign bus.data_rdy   = (state == ST_DONE) && !owner_inst;
  assign bus.inst_busy  = owner_inst && ((state == ST_READ) || (state == ST_WRITE));
  assign bus.data_busy  = !owner_inst && ((state == ST_READ) || (state == ST_WRITE));
  assign bus.inst_data  = inst_data_q;
  assign bus.data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed self-checking bench for mem_arbiter_ctrl with a one-cycle-latency RAM model.
module tb_mem_arbiter_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] mem [logic [31:0]];
  logic [7:0] eb [4];
  bit   seen;

  mem_arbiter_ctrl_if #(.ADDR_W(32)) bus();

  mem_arbiter_ctrl #(.ADDR_W(32), .IO_MASK_HI(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ram_din in cycle c reflects ram_a of cycle c-1
  always @(posedge clk)
    bus.ram_din <= mem.exists(bus.ram_a) ? mem[bus.ram_a] : 8'h00;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string p);
    chk1 ({p, "_inst_rdy"},  bus.inst_rdy,  1'b0);
    chk1 ({p, "_inst_busy"}, bus.inst_busy, 1'b0);
    chk1 ({p, "_data_rdy"},  bus.data_rdy,  1'b0);
    chk1 ({p, "_data_busy"}, bus.data_busy, 1'b0);
    chk1 ({p, "_ram_wr"},    bus.ram_wr,    1'b0);
    chk32({p, "_ram_a"},     bus.ram_a,     32'h0);
    chk32({p, "_ram_dout"},  {24'h0, bus.ram_dout}, 32'h0);
    chk32({p, "_inst_data"}, bus.inst_data, 32'h0);
    chk32({p, "_data_rdata"},bus.data_rdata,32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
    mem[32'h200] = 8'hAB; mem[32'h201] = 8'hCD;
    mem[32'h400] = 8'h11; mem[32'h401] = 8'h22; mem[32'h402] = 8'h33; mem[32'h403] = 8'h44;
    mem[32'h500] = 8'h55; mem[32'h501] = 8'h66; mem[32'h502] = 8'h77; mem[32'h503] = 8'h88;
    eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE;

    rst = 1'b1;
    bus.inst_needed = 1'b0; bus.inst_addr = 32'h0; bus.inst_cancel = 1'b0;
    bus.data_needed = 1'b0; bus.data_wr = 1'b0; bus.data_len = 2'b00;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0; bus.io_buffer_full = 1'b0;
    repeat (2) go();
    smp();
    chk_all_zero("reset");
    go();
    rst = 1'b0;

    // 4-byte fetch from 0x100
    go();
    bus.inst_needed = 1'b1; bus.inst_addr = 32'h100;
    smp();
    chk1("t1_c0_busy", bus.inst_busy, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      go();
      bus.inst_needed = 1'b0;
      smp();
      chk1($sformatf("t1_c%0d_busy", c), bus.inst_busy, c <= 5);
      chk1($sformatf("t1_c%0d_rdy", c), bus.inst_rdy, c == 6);
      if (c <= 4) begin
        chk32($sformatf("t1_c%0d_ram_a", c), bus.ram_a, 32'h100 + 32'(c) - 32'd1);
        chk1 ($sformatf("t1_c%0d_ram_wr", c), bus.ram_wr, 1'b0);
      end
      if (c >= 6) chk32($sformatf("t1_c%0d_inst_data", c), bus.inst_data, 32'h0000_0513);
    end

    // simultaneous requests: data wins, fetch follows in the next IDLE cycle
    go();
    bus.data_needed = 1'b1; bus.data_wr = 1'b0; bus.data_len = 2'b01; bus.data_addr = 32'h200;
    bus.inst_needed = 1'b1; bus.inst_addr = 32'h100;
    smp();
    chk1("t2_c0_data_busy", bus.data_busy, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      go();
      bus.data_needed = 1'b0;
      smp();
      chk1($sformatf("t2_c%0d_data_busy", c), bus.data_busy, c <= 3);
      chk1($sformatf("t2_c%0d_data_rdy", c), bus.data_rdy, c == 4);
      chk1($sformatf("t2_c%0d_inst_busy", c), bus.inst_busy, 1'b0);
      if (c <= 2) chk32($sformatf("t2_c%0d_ram_a", c), bus.ram_a, 32'h200 + 32'(c) - 32'd1);
      if (c == 4) chk32("t2_data_rdata", bus.data_rdata, 32'h0000_CDAB);
    end
    go();
    bus.inst_needed = 1'b0;
    smp();
    chk1 ("t2_fetch_busy", bus.inst_busy, 1'b1);
    chk32("t2_fetch_ram_a", bus.ram_a, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      go();
      smp();
      if (bus.inst_rdy) seen = 1'b1;
    end
    chk1 ("t2_fetch_rdy_seen", seen, 1'b1);
    chk32("t2_fetch_data", bus.inst_data, 32'h0000_0513);

    // 4-byte store; io_buffer_full must not stall a non-IO address
    go();
    bus.data_needed = 1'b1; bus.data_wr = 1'b1; bus.data_len = 2'b10;
    bus.data_addr = 32'h300; bus.data_wdata = 32'hDEAD_BEEF; bus.io_buffer_full = 1'b1;
    smp();
    for (int c = 1; c <= 5; c++) begin
      go();
      bus.data_needed = 1'b0;
      smp();
      chk1($sformatf("t3_c%0d_ram_wr", c), bus.ram_wr, c <= 4);
      chk1($sformatf("t3_c%0d_data_busy", c), bus.data_busy, c <= 4);
      chk1($sformatf("t3_c%0d_data_rdy", c), bus.data_rdy, c == 5);
      if (c <= 4) begin
        chk32($sformatf("t3_c%0d_ram_a", c), bus.ram_a, 32'h300 + 32'(c) - 32'd1);
        chk32($sformatf("t3_c%0d_ram_dout", c), {24'h0, bus.ram_dout}, {24'h0, eb[c-1]});
      end
    end
    bus.io_buffer_full = 1'b0;

    // 1-byte IO store held by io_buffer_full for cycles 1-3
    go();
    bus.data_needed = 1'b1; bus.data_wr = 1'b1; bus.data_len = 2'b00;
    bus.data_addr = 32'h0003_0004; bus.data_wdata = 32'h0000_00A5;
    smp();
    for (int c = 1; c <= 5; c++) begin
      go();
      bus.data_needed = 1'b0;
      bus.io_buffer_full = (c <= 3);
      smp();
      chk1($sformatf("t4_c%0d_ram_wr", c), bus.ram_wr, c == 4);
      chk1($sformatf("t4_c%0d_data_busy", c), bus.data_busy, c <= 4);
      chk1($sformatf("t4_c%0d_data_rdy", c), bus.data_rdy, c == 5);
      if (c <= 4) chk32($sformatf("t4_c%0d_ram_a", c), bus.ram_a, 32'h0003_0004);
      if (c == 4) chk32("t4_ram_dout", {24'h0, bus.ram_dout}, 32'h0000_00A5);
    end
    bus.io_buffer_full = 1'b0;

    // fetch cancelled in cycle 2; a data request in cycle 7 proves the FSM is IDLE
    go();
    bus.inst_needed = 1'b1; bus.inst_addr = 32'h400;
    smp();
    for (int c = 1; c <= 7; c++) begin
      go();
      bus.inst_needed = 1'b0;
      bus.inst_cancel = (c == 2);
      if (c == 7) begin
        bus.data_needed = 1'b1; bus.data_wr = 1'b0; bus.data_len = 2'b10; bus.data_addr = 32'h500;
      end
      smp();
      chk1($sformatf("t5_c%0d_inst_rdy", c), bus.inst_rdy, 1'b0);
      chk1($sformatf("t5_c%0d_inst_busy", c), bus.inst_busy, c <= 5);
      if (c <= 4) chk32($sformatf("t5_c%0d_ram_a", c), bus.ram_a, 32'h400 + 32'(c) - 32'd1);
    end

    // reset in cycle 3 of the 4-byte load accepted above
    go();
    bus.data_needed = 1'b0;
    smp();
    chk1 ("t6_c1_data_busy", bus.data_busy, 1'b1);
    chk32("t6_c1_ram_a", bus.ram_a, 32'h500);
    go();
    smp();
    go();
    rst = 1'b1;
    smp();
    chk1("t6_c3_data_rdy", bus.data_rdy, 1'b0);
    go();
    rst = 1'b0;
    bus.data_needed = 1'b1; bus.data_wr = 1'b0; bus.data_len = 2'b00; bus.data_addr = 32'h200;
    smp();
    chk_all_zero("t6_after_rst");
    go();
    bus.data_needed = 1'b0;
    smp();
    chk1 ("t6_new_busy", bus.data_busy, 1'b1);
    chk32("t6_new_ram_a", bus.ram_a, 32'h200);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      go();
      smp();
      if (bus.data_rdy) seen = 1'b1;
    end
    chk1 ("t6_new_rdy_seen", seen, 1'b1);
    chk32("t6_new_rdata", bus.data_rdata, 32'h0000_00AB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Single owner of the byte-wide unified RAM/IO bus.
- Arbitrates between the instruction-fetch/i-cache port and the MEM-stage data port.
- Serialises each accepted 1/2/4-byte access into per-byte RAM cycles and returns one assembled little-endian word with a single-cycle ready pulse.
- Sits between the IF i-cache, the MEM stage and the top-level RAM/IO pins.

Parameters:
ADDR_W, 32, address width on every port
IO_MASK_HI, 17, upper bit of the IO region select; addr[17:16]==2'b11 selects IO

Ports:
clk  in  1  clock
rst  in  1  reset
inst_needed  in  1  fetch request; only sampled in IDLE
inst_addr  in  32  fetch byte address; always 4 bytes
inst_cancel  in  1  flush; suppresses the pending fetch result
inst_rdy  out  1  one-cycle pulse; inst_data valid
inst_busy  out  1  a fetch is in flight
inst_data  out  32  assembled instruction
data_needed  in  1  data request; only sampled in IDLE
data_wr  in  1  1=store, 0=load
data_len  in  2  00=1 B, 01=2 B, 10/11=4 B
data_addr  in  32  data byte address
data_wdata  in  32  store data; low bytes used
data_rdy  out  1  one-cycle pulse
data_busy  out  1  a data access is in flight
data_rdata  out  32  load data, zero-extended
ram_din  in  8  RAM/IO read byte
ram_dout  out  8  RAM/IO write byte
ram_a  out  32  RAM/IO byte address
ram_wr  out  1  1=write, 0=read
io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset is synchronous, active-high on rst; clock is clk.
  - Every output resets to 0 and the FSM goes to IDLE.
  - Reset mid-operation aborts the access: no rdy pulse, partial bytes are discarded.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - If data_needed, latch addr, len, wr and wdata with owner=DATA.
  - Else if inst_needed, latch addr with len=4, wr=0, owner=INST.
  - Data always wins when both are requested.
  - Next state is READ or WRITE, and the byte counter k is cleared to 0.
  - When idle, ram_wr=0 and ram_a holds its last value.
- RAM timing: ram_din in cycle c reflects the address driven in cycle c-1.
- READ of N bytes (accept cycle = cycle 0):
  - Cycles 1..N drive ram_a=addr+k, ram_wr=0.
  - Cycles 2..N+1 capture ram_din into byte k-1 of the buffer, where byte 0 is bits [7:0].
  - The cycle after the last capture is DONE (cycle N+2).
- WRITE of N bytes:
  - Each byte cycle drives ram_a=addr+k, ram_wr=1, ram_dout=wdata[8k+7:8k].
  - If addr[17:16]==2'b11 and io_buffer_full, the cycle holds: ram_wr=0 and k does not advance.
  - After the last byte, go to DONE. With no holds, DONE is cycle N+1.
- DONE (one cycle):
  - Pulse the owner's rdy and present the owner's data, zero-extended for 1/2-byte loads.
  - Next state is IDLE. A request present during DONE is not accepted until the IDLE cycle.
- busy:
  - owner_busy=1 in READ/WRITE only; it is 0 in IDLE and DONE.
  - The other port's busy stays 0.
- inst_cancel:
  - If asserted in any cycle while owner=INST and state is READ or DONE, the sequence still completes on the RAM side.
  - inst_rdy is suppressed, and the cancel is sticky until IDLE.
  - inst_cancel has no effect on data accesses.
- Output registers: inst_data and data_rdata keep their last value outside the rdy cycle.
- Byte counter is 3 bits. Address increment is a full 32-bit add; wrap at 2^32 is allowed, no trap.

Decomposition:
- Shared package (config.vh):
  - state encodings;
  - data_len codes LEN_B, LEN_H, LEN_W;
  - IO_REGION constant 2'b11;
  - ZERO_WORD;
  - reuse of the existing ResetEnable.
- One natural sub-module: mem_byte_assembler. It holds the 4x8 shift/assemble buffer with zero-extension by len and the write-byte select.

Test Plan:
- Inst fetch, addr 0x100, RAM bytes 13 05 00 00 -> inst_rdy pulses in cycle 6 (accept = cycle 0) with inst_data=0x00000513; inst_busy high in cycles 1-5.
- data_needed and inst_needed both high in IDLE, load len=01 addr 0x200 with bytes AB CD -> data_rdy in cycle 4 with 0x0000CDAB. Fetch is accepted in the following IDLE cycle; inst_busy stays 0 until then.
- Store len=10 addr 0x300 wdata 0xDEADBEEF -> cycles 1-4 show ram_wr=1 with ram_a 0x300..0x303 and ram_dout EF BE AD DE; data_rdy in cycle 5.
- Store len=00 addr 0x30004 with io_buffer_full high for cycles 1-3 -> ram_wr=0 in cycles 1-3, write of byte in cycle 4, data_rdy in cycle 5.
- Fetch accepted, inst_cancel pulsed in cycle 2 -> RAM reads continue through cycle 4, no inst_rdy, IDLE in cycle 7.
- rst asserted in cycle 3 of a 4-byte load -> all outputs 0 next cycle, no data_rdy, new request accepted immediately after rst drops.
